id_stage: RTL

- RV32I instruction-decode stage directly upstream of the register file.
- Drives the register-file read addresses from the fetched instruction and decodes opcode, immediate and control fields.
- Forwards the write-back result when the register file cannot yet show it, detects load-use hazards, and registers everything into the ID/EX pipeline register consumed by the execute stage.
- Handshake: if_valid/if_ready on the fetch side; one-cycle latency to the ex_* outputs.

---
 rtl/id_stage.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// RV32I instruction-decode stage.
// Operand read/forwarding, load-use stall and the ID/EX pipeline register.
package id_stage_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       auipc;
        logic       illegal;
    } ctrl_t;

endpackage

module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    output logic [RA_W-1:0] rf_rs1,
    output logic [RA_W-1:0] rf_rs2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src_imm,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic            ex_auipc,
    output logic            ex_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7b5;
    logic [RA_W-1:0] rd;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign f7b5   = if_instr[30];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = if_instr[19:15];
    assign rf_rs2 = if_instr[24:20];

    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);

    // The register file only shows a write after the edge, so
    // a same-cycle write-back is bypassed here. x0 never bypasses.
    logic            fwd1;
    logic            fwd2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign fwd1 = wb_reg_write && (wb_rd != '0)
                  && (wb_rd == rf_rs1);
    assign fwd2 = wb_reg_write && (wb_rd != '0)
                  && (wb_rd == rf_rs2);
    assign op1  = fwd1 ? wb_data : rf_rd1;
    assign op2  = fwd2 ? wb_data : rf_rd2;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = XLEN'($signed(if_instr[31:20]));
    assign imm_s = XLEN'($signed({if_instr[31:25],
                                  if_instr[11:7]}));
    assign imm_b = XLEN'($signed({if_instr[31],
                                  if_instr[7],
                                  if_instr[30:25],
                                  if_instr[11:8],
                                  1'b0}));
    assign imm_u = XLEN'($signed({if_instr[31:12],
                                  12'b0}));
    assign imm_j = XLEN'($signed({if_instr[31],
                                  if_instr[19:12],
                                  if_instr[20],
                                  if_instr[30:21],
                                  1'b0}));

    logic [3:0] alu_base;
    logic [3:0] alu_rr;
    logic [3:0] alu_ri;

    // ALU op from funct3; funct7[5] picks SUB/SRA (only SRAI for I-ALU)
    always_comb begin
        alu_base = ALU_ADD;
        unique case (funct3)
            3'b000: alu_base = ALU_ADD;
            3'b001: alu_base = ALU_SLL;
            3'b010: alu_base = ALU_SLT;
            3'b011: alu_base = ALU_SLTU;
            3'b100: alu_base = ALU_XOR;
            3'b101: alu_base = ALU_SRL;
            3'b110: alu_base = ALU_OR;
            3'b111: alu_base = ALU_AND;
        endcase
        alu_rr = alu_base;
        alu_ri = alu_base;
        if (f7b5 && funct3 == 3'b000) begin
            alu_rr = ALU_SUB;
        end
        if (f7b5 && funct3 == 3'b101) begin
            alu_rr = ALU_SRA;
            alu_ri = ALU_SRA;
        end
    end

    ctrl_t           dec;
    logic [XLEN-1:0] dec_imm;
    logic            rs1_used;
    logic            rs2_used;

    // Opcode decode into control bundle, immediate and source usage
    always_comb begin
        dec      = '0;
        dec_imm  = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        unique case (1'b1)
            is_r: begin
                dec.alu_op    = alu_rr;
                dec.reg_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            is_i: begin
                dec.alu_op      = alu_ri;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec_imm         = imm_i;
                rs1_used        = 1'b1;
            end
            is_load: begin
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.mem_read    = 1'b1;
                dec.reg_write   = 1'b1;
                dec_imm         = imm_i;
                rs1_used        = 1'b1;
            end
            is_store: begin
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
                dec_imm         = imm_s;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
            end
            is_branch: begin
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
                dec_imm    = imm_b;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            is_jal: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec_imm       = imm_j;
            end
            is_jalr: begin
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.jump        = 1'b1;
                dec.jalr        = 1'b1;
                dec.reg_write   = 1'b1;
                dec_imm         = imm_i;
                rs1_used        = 1'b1;
            end
            is_lui: begin
                dec.alu_op      = ALU_PASSB;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec_imm         = imm_u;
            end
            is_auipc: begin
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.auipc       = 1'b1;
                dec.reg_write   = 1'b1;
                dec_imm         = imm_u;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (rd == '0) begin
            dec.reg_write = 1'b0;
        end
    end

    // A load in EX cannot be bypassed yet; hold the consumer one cycle.
    logic stall;
    logic issue;

    assign stall = if_valid && ex_valid && ex_mem_read
                   && (ex_rd != '0)
                   && ((rs1_used && ex_rd == rf_rs1)
                       || (rs2_used && ex_rd == rf_rs2));
    assign if_ready = !stall || flush;
    assign issue    = if_valid && !stall && !flush;

    // ID/EX register: bubble on reset, flush, stall or empty slot
    always_ff @(posedge clk) begin
        if (!rst_n || !issue) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            ex_rs1_val     <= '0;
            ex_rs2_val     <= '0;
            ex_imm         <= '0;
            ex_rd          <= '0;
            ex_funct3      <= '0;
            ex_alu_op      <= '0;
            ex_alu_src_imm <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_branch      <= 1'b0;
            ex_jump        <= 1'b0;
            ex_jalr        <= 1'b0;
            ex_auipc       <= 1'b0;
            ex_illegal     <= 1'b0;
        end else begin
            ex_valid       <= 1'b1;
            ex_pc          <= if_pc;
            ex_rs1_val     <= op1;
            ex_rs2_val     <= op2;
            ex_imm         <= dec_imm;
            ex_rd          <= rd;
            ex_funct3      <= funct3;
            ex_alu_op      <= dec.alu_op;
            ex_alu_src_imm <= dec.alu_src_imm;
            ex_mem_read    <= dec.mem_read;
            ex_mem_write   <= dec.mem_write;
            ex_reg_write   <= dec.reg_write;
            ex_branch      <= dec.branch;
            ex_jump        <= dec.jump;
            ex_jalr        <= dec.jalr;
            ex_auipc       <= dec.auipc;
            ex_illegal     <= dec.illegal;
        end
    end

endmodule
